seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display controller, the next-generation replacement for the fixed 8-digit interface. It latches N_DIGITS hex nibbles plus decimal points on a load strobe and scans them onto common-anode digits at a programmable per-digit refresh period. It adds programmable brightness (PWM within each digit slot), optional leading-zero blanking and a frame-complete pulse. It sits between datapath result registers and the board's anode/cathode pins.

---
 rtl/seg7_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode 7-segment scanner.
// Latches N_DIGITS hex nibbles plus decimal points on i_load. Each digit is
// shown for TICK_DIV clocks. Brightness is set by PWM within each slot, and
// leading zeros can be blanked. A frame-complete pulse is also produced.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_data, i_dp      nibbles (digit 0 in bits [3:0]) and decimal points
//   i_load            capture i_data/i_dp into the display register
//   i_blank_lz        live leading-zero blanking enable
//   i_brightness      PWM on-time code, sampled at each slot start
//   o_anode           active-low digit enables
//   o_cathode         active-low segments {g,f,e,d,c,b,a}
//   o_dp_n            active-low decimal point
//   o_frame_done      one-cycle pulse when the last digit slot ends
module seg7_scan_ctrl #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DIM_W    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*N_DIGITS-1:0] i_data,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  i_load,
  input  logic                  i_blank_lz,
  input  logic [DIM_W-1:0]      i_brightness,
  output logic [N_DIGITS-1:0]   o_anode,
  output logic [6:0]            o_cathode,
  output logic                  o_dp_n,
  output logic                  o_frame_done
);

  localparam int unsigned SUB_N = TICK_DIV >> DIM_W;
  localparam int unsigned SUB_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;
  localparam int unsigned SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [SUB_W-1:0]      r_sub;
  logic [DIM_W-1:0]      r_phase;
  logic [DIM_W-1:0]      r_bright;
  logic [SEL_W-1:0]      r_sel;
  logic [4*N_DIGITS-1:0] r_disp;
  logic [N_DIGITS-1:0]   r_dp;

  logic                  w_sub_wrap;
  logic                  w_slot_adv;
  logic                  w_sel_last;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_zero_sel;
  logic [N_DIGITS-1:0]   w_zero;
  logic                  w_blank;
  logic                  w_on;
  logic [N_DIGITS-1:0]   w_anode_nx;
  logic [6:0]            w_cathode_nx;
  logic                  w_dp_n_nx;

  // Hex to active-low {g..a}.
  function automatic logic [6:0] f_hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A slot ends when the last phase's sub-count wraps.
  assign w_sub_wrap = (r_sub == SUB_W'(SUB_N - 1));
  assign w_slot_adv = w_sub_wrap && (r_phase == {DIM_W{1'b1}});
  assign w_sel_last = (r_sel == SEL_W'(N_DIGITS - 1));

  // w_zero[i]: digits i and above all show 0 with no decimal point lit.
  always_comb begin
    w_zero = '0;
    w_zero[N_DIGITS-1] = (r_disp[4*N_DIGITS-1 -: 4] == 4'h0) && !r_dp[N_DIGITS-1];
    for (int i = int'(N_DIGITS) - 2; i >= 0; i--) begin
      w_zero[i] = w_zero[i+1] && (r_disp[4*i +: 4] == 4'h0) && !r_dp[i];
    end
  end

  // Selected digit's nibble, decimal point and zero-chain bit.
  always_comb begin
    w_nib      = 4'h0;
    w_dp_sel   = 1'b0;
    w_zero_sel = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_nib      = r_disp[4*i +: 4];
        w_dp_sel   = r_dp[i];
        w_zero_sel = w_zero[i];
      end
    end
  end

  assign w_blank = i_blank_lz && (r_sel != '0) && w_zero_sel;
  assign w_on    = (r_phase <= r_bright);

  // Next pin values; anode and cathode are updated together on the same edge.
  always_comb begin
    w_anode_nx   = '1;
    w_cathode_nx = 7'h7F;
    w_dp_n_nx    = 1'b1;
    if (w_on && !w_blank) begin
      w_anode_nx   = ~(N_DIGITS'(1) << r_sel);
      w_cathode_nx = f_hex7(w_nib);
      w_dp_n_nx    = ~w_dp_sel;
    end
  end

  // Scan counters, display register and registered pins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sub        <= '0;
      r_phase      <= '0;
      r_bright     <= '0;
      r_sel        <= '0;
      r_disp       <= '0;
      r_dp         <= '0;
      o_anode      <= '1;
      o_cathode    <= 7'h7F;
      o_dp_n       <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      r_sub <= w_sub_wrap ? '0 : r_sub + SUB_W'(1);
      if (w_sub_wrap) begin
        r_phase <= r_phase + DIM_W'(1);
      end
      if (w_slot_adv) begin
        r_sel    <= w_sel_last ? '0 : r_sel + SEL_W'(1);
        r_bright <= i_brightness;
      end
      if (i_load) begin
        r_disp <= i_data;
        r_dp   <= i_dp;
      end
      o_anode      <= w_anode_nx;
      o_cathode    <= w_cathode_nx;
      o_dp_n       <= w_dp_n_nx;
      o_frame_done <= w_slot_adv && w_sel_last;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (4 digits, 8 clocks per slot, 2 clocks per phase).
// Expected pin values are pushed to a queue as each window of stimulus is set
// up. They are popped and compared one per clock, #1 after the rising edge.
module tb_seg7_scan_ctrl;

  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned TICK_DIV = 8;
  localparam int unsigned DIM_W    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [1:0]  brightness = '0;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp_n;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int cyc;  // rising edges since reset release

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] ca;
    logic       dpn;
    logic       fd;
  } pins_t;

  pins_t sb_q[$];

  seg7_scan_ctrl #(.N_DIGITS(N_DIGITS), .TICK_DIV(TICK_DIV), .DIM_W(DIM_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_load(load),
    .i_blank_lz(blank_lz), .i_brightness(brightness),
    .o_anode(anode), .o_cathode(cathode), .o_dp_n(dp_n), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // Pins visible after edge n reflect the scan position reached at edge n-1.
  function automatic pins_t model(input int n, input logic [15:0] d, input logic [3:0] dpv,
                                  input bit blz, input logic [1:0] br);
    int m, s, ph;
    logic [15:0] hi;
    logic [3:0]  dhi;
    bit          blanked;
    pins_t       p;
    m  = n - 1;
    s  = (m / 8) % 4;
    ph = (m / 2) % 4;
    hi  = d >> (4 * s);
    dhi = dpv >> s;
    blanked = blz && (s != 0) && (hi == 16'h0) && (dhi == 4'h0);
    p.fd = (n > 0) && (n % 32 == 0);
    if ((ph <= int'(br)) && !blanked) begin
      p.an  = ~(4'b0001 << s);
      p.ca  = seg_ref(d[4*s +: 4]);
      p.dpn = ~dpv[s];
    end else begin
      p.an  = 4'hF;
      p.ca  = 7'h7F;
      p.dpn = 1'b1;
    end
    return p;
  endfunction

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_pins_off(input string tag);
    chk({tag, ".anode"}, 32'(anode), 32'hF);
    chk({tag, ".cathode"}, 32'(cathode), 32'h7F);
    chk({tag, ".dp_n"}, 32'(dp_n), 32'h1);
    chk({tag, ".frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Queue the expected pins for the next ncyc clocks, then check them.
  task automatic check_span(input string tag, input int ncyc, input logic [15:0] d,
                            input logic [3:0] dpv, input bit blz, input logic [1:0] br);
    pins_t p;
    for (int k = 1; k <= ncyc; k++) sb_q.push_back(model(cyc + k, d, dpv, blz, br));
    for (int k = 0; k < ncyc; k++) begin
      step(1);
      p = sb_q.pop_front();
      chk($sformatf("%s.anode@%0d", tag, cyc), 32'(anode), 32'(p.an));
      chk($sformatf("%s.cathode@%0d", tag, cyc), 32'(cathode), 32'(p.ca));
      chk($sformatf("%s.dp_n@%0d", tag, cyc), 32'(dp_n), 32'(p.dpn));
      chk($sformatf("%s.frame_done@%0d", tag, cyc), 32'(frame_done), 32'(p.fd));
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv);
    data = d;
    dp   = dpv;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic to_slot_start();
    step(1);
    for (int g = 0; g < 16 && (cyc % 8) != 0; g++) step(1);
  endtask

  task automatic to_frame_pos(input int pos);
    step(1);
    for (int g = 0; g < 64 && (cyc % 32) != pos; g++) step(1);
  endtask

  initial begin
    // Asynchronous reset with arbitrary inputs, including a load request.
    #2;
    rst        = 1'b1;
    data       = 16'($urandom);
    dp         = 4'($urandom);
    load       = 1'b1;
    blank_lz   = 1'($urandom);
    brightness = 2'($urandom);
    #1;
    check_pins_off("rst_async");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_pins_off($sformatf("rst_hold%0d", k));
    end
    @(negedge clk);
    load       = 1'b0;
    data       = '0;
    dp         = '0;
    blank_lz   = 1'b0;
    brightness = 2'd3;
    rst        = 1'b0;

    // First slot: digit 0, cleared data, brightness code 0.
    check_span("release", 2, 16'h0000, 4'h0, 1'b0, 2'd0);
    do_load(16'h12AF, 4'h0);
    check_span("slot0_dim", 5, 16'h12AF, 4'h0, 1'b0, 2'd0);

    // Full-brightness scan over two frames.
    to_frame_pos(0);
    check_span("scan", 64, 16'h12AF, 4'h0, 1'b0, 2'd3);

    // Brightness codes and a mid-slot change.
    brightness = 2'd0;
    to_slot_start();
    check_span("br0", 32, 16'h12AF, 4'h0, 1'b0, 2'd0);
    brightness = 2'd1;
    to_slot_start();
    check_span("br1", 8, 16'h12AF, 4'h0, 1'b0, 2'd1);
    step(3);
    brightness = 2'd3;
    check_span("br_mid", 5, 16'h12AF, 4'h0, 1'b0, 2'd1);
    check_span("br_next", 8, 16'h12AF, 4'h0, 1'b0, 2'd3);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0030, 4'h0);
    to_slot_start();
    check_span("lz_0030", 32, 16'h0030, 4'h0, 1'b1, 2'd3);
    do_load(16'h0000, 4'h0);
    to_slot_start();
    check_span("lz_0000", 32, 16'h0000, 4'h0, 1'b1, 2'd3);
    do_load(16'h0030, 4'b0100);
    to_slot_start();
    check_span("lz_dp", 32, 16'h0030, 4'b0100, 1'b1, 2'd3);

    // Load on the same edge as a slot advance.
    for (int g = 0; g < 16 && (cyc % 8) != 7; g++) step(1);
    data = 16'h5555;
    dp   = 4'h0;
    load = 1'b1;
    step(1);
    load = 1'b0;
    check_span("collide", 8, 16'h5555, 4'h0, 1'b1, 2'd3);

    // Reset during digit 2 slot, then restart from digit 0.
    blank_lz = 1'b0;
    to_frame_pos(16);
    step(3);
    #2;
    rst = 1'b1;
    #1;
    check_pins_off("midrst_async");
    @(negedge clk);
    check_pins_off("midrst_hold");
    @(negedge clk);
    rst = 1'b0;
    check_span("midrst_rel", 8, 16'h0000, 4'h0, 1'b0, 2'd0);
    check_span("midrst_adv", 8, 16'h0000, 4'h0, 1'b0, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
